// File: rtl/ycbcr2rgb_stream.sv
// ycbcr2rgb_stream: BT.601 full-range YCbCr to RGB converter.
// Input is 12-bit unsigned Y/Cb/Cr with 4 fractional bits. Output is packed 8-bit {R,G,B}.
// The block has a 3-stage valid/ready pipeline that stalls as one unit.
// Frame/line sideband travels with each pixel. A saturating counter tracks clipped pixels.
// Build option YCBCR2RGB_SKID_EN registers s_ready behind a 2-entry input skid
// buffer, which removes the m_ready -> s_ready path and adds one cycle of latency.
module ycbcr2rgb_stream #(
  parameter int PIXEL_WIDTH      = 24,
  parameter int RGB_WIDTH        = 8,
  parameter int YCbCr_WIDTH      = 12,
  parameter int YCbCr_PARA_WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [3*YCbCr_WIDTH-1:0] s_ycbcr,
  input  logic                     s_sof,
  input  logic                     s_eol,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [PIXEL_WIDTH-1:0]   m_rgb,
  output logic                     m_sof,
  output logic                     m_eol,
  input  logic                     sat_clr,
  output logic [15:0]              sat_cnt
);

  localparam int FRAC_W    = YCbCr_WIDTH - RGB_WIDTH;
  localparam int COEF_FRAC = 16;
  localparam int SHIFT     = COEF_FRAC + FRAC_W;
  localparam int COEF_W    = 18;
  localparam int C_W       = YCbCr_WIDTH + 1;
  localparam int PROD_W    = C_W + COEF_W;
  localparam int SUM_W     = PROD_W + 2;
  localparam int IN_W      = 3*YCbCr_WIDTH + 2;

  localparam logic [YCbCr_PARA_WIDTH-1:0] K_RV = YCbCr_PARA_WIDTH'(91881);
  localparam logic [YCbCr_PARA_WIDTH-1:0] K_GU = YCbCr_PARA_WIDTH'(22554);
  localparam logic [YCbCr_PARA_WIDTH-1:0] K_GV = YCbCr_PARA_WIDTH'(46802);
  localparam logic [YCbCr_PARA_WIDTH-1:0] K_BU = YCbCr_PARA_WIDTH'(116130);

  // Coefficients fit in 17 bits; one extra bit keeps them positive as signed operands.
  localparam logic signed [COEF_W-1:0] C_RV = COEF_W'(K_RV);
  localparam logic signed [COEF_W-1:0] C_GU = COEF_W'(K_GU);
  localparam logic signed [COEF_W-1:0] C_GV = COEF_W'(K_GV);
  localparam logic signed [COEF_W-1:0] C_BU = COEF_W'(K_BU);

  localparam logic signed [C_W-1:0]   CENTER = C_W'(1 << (YCbCr_WIDTH-1));
  localparam logic signed [SUM_W-1:0] ROUND  = SUM_W'(64'd1 << (SHIFT-1));
  localparam logic signed [SUM_W-1:0] MAXV   = SUM_W'((1 << RGB_WIDTH) - 1);

  logic                   advance;
  logic                   inValid;
  logic [IN_W-1:0]        inData;

  logic                   valid1_q, sof1_q, eol1_q;
  logic [YCbCr_WIDTH-1:0] y1_q, y1_d;
  logic signed [C_W-1:0]  cb1_q, cr1_q, cb1_d, cr1_d;

  logic                   valid2_q, sof2_q, eol2_q;
  logic [YCbCr_WIDTH-1:0] y2_q;
  logic signed [PROD_W-1:0] prRv_q, prGu_q, prGv_q, prBu_q;
  logic signed [PROD_W-1:0] prRv_d, prGu_d, prGv_d, prBu_d;

  logic                   valid3_q, sof3_q, eol3_q, clip3_q, clip3_d;
  logic [PIXEL_WIDTH-1:0] rgb3_q, rgb3_d;

  logic signed [SUM_W-1:0] y20, rSum, gSum, bSum;
  logic [RGB_WIDTH:0]      rCh, gCh, bCh;

  logic [15:0]            satCnt_q;

  // The whole pipe moves only when the output register is empty or being drained.
  assign advance = ~valid3_q | m_ready;

`ifdef YCBCR2RGB_SKID_EN
  logic [IN_W-1:0] skid_q [2];
  logic            wrPtr_q, rdPtr_q;
  logic [1:0]      count_q, count_d;
  logic            sReady_q;
  logic            push, pop;

  assign push    = s_valid & sReady_q;
  assign pop     = advance & (count_q != 2'd0);
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};
  assign inValid = (count_q != 2'd0);
  assign inData  = skid_q[rdPtr_q];
  assign s_ready = sReady_q;

  // Two-entry input FIFO; ready is registered from the next fill level so it never depends on m_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      count_q   <= 2'd0;
      sReady_q  <= 1'b0;
    end else begin
      if (push) begin
        skid_q[wrPtr_q] <= {s_ycbcr, s_sof, s_eol};
        wrPtr_q         <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q  <= count_d;
      sReady_q <= (count_d != 2'd2);
    end
  end
`else
  assign inValid = s_valid;
  assign inData  = {s_ycbcr, s_sof, s_eol};
  assign s_ready = advance;
`endif

  // Round half up to the 8-bit grid, then clamp; the top bit flags a clamp.
  function automatic logic [RGB_WIDTH:0] clampCh(input logic signed [SUM_W-1:0] v);
    logic signed [SUM_W-1:0] r;
    r = (v + ROUND) >>> SHIFT;
    if (r[SUM_W-1]) begin
      clampCh = {1'b1, {RGB_WIDTH{1'b0}}};
    end else if (r > MAXV) begin
      clampCh = {1'b1, {RGB_WIDTH{1'b1}}};
    end else begin
      clampCh = {1'b0, r[RGB_WIDTH-1:0]};
    end
  endfunction

  // Stage 1 inputs: split Y and centre the chroma around zero.
  always_comb begin
    y1_d  = inData[IN_W-1 -: YCbCr_WIDTH];
    cb1_d = $signed({1'b0, inData[IN_W-1-YCbCr_WIDTH -: YCbCr_WIDTH]}) - CENTER;
    cr1_d = $signed({1'b0, inData[2+YCbCr_WIDTH-1 -: YCbCr_WIDTH]}) - CENTER;
  end

  // Stage 2 inputs: the four chroma products, scaled 2^-20.
  always_comb begin
    prRv_d = PROD_W'(cr1_q) * PROD_W'(C_RV);
    prGu_d = PROD_W'(cb1_q) * PROD_W'(C_GU);
    prGv_d = PROD_W'(cr1_q) * PROD_W'(C_GV);
    prBu_d = PROD_W'(cb1_q) * PROD_W'(C_BU);
  end

  // Stage 3 inputs: sum each channel on the common 2^-20 scale, round, and clamp.
  always_comb begin
    y20     = $signed({{(SUM_W-YCbCr_WIDTH){1'b0}}, y2_q}) <<< COEF_FRAC;
    rSum    = y20 + SUM_W'(prRv_q);
    gSum    = y20 - SUM_W'(prGu_q) - SUM_W'(prGv_q);
    bSum    = y20 + SUM_W'(prBu_q);
    rCh     = clampCh(rSum);
    gCh     = clampCh(gSum);
    bCh     = clampCh(bSum);
    rgb3_d  = {rCh[RGB_WIDTH-1:0], gCh[RGB_WIDTH-1:0], bCh[RGB_WIDTH-1:0]};
    clip3_d = rCh[RGB_WIDTH] | gCh[RGB_WIDTH] | bCh[RGB_WIDTH];
  end

  // All three stages load together so data, valid and sideband never separate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;  sof1_q <= 1'b0;  eol1_q <= 1'b0;
      y1_q     <= '0;    cb1_q  <= '0;    cr1_q  <= '0;
      valid2_q <= 1'b0;  sof2_q <= 1'b0;  eol2_q <= 1'b0;
      y2_q     <= '0;
      prRv_q   <= '0;    prGu_q <= '0;    prGv_q <= '0;    prBu_q <= '0;
      valid3_q <= 1'b0;  sof3_q <= 1'b0;  eol3_q <= 1'b0;
      rgb3_q   <= '0;    clip3_q <= 1'b0;
    end else if (advance) begin
      valid1_q <= inValid;
      sof1_q   <= inData[1];
      eol1_q   <= inData[0];
      y1_q     <= y1_d;
      cb1_q    <= cb1_d;
      cr1_q    <= cr1_d;
      valid2_q <= valid1_q;
      sof2_q   <= sof1_q;
      eol2_q   <= eol1_q;
      y2_q     <= y1_q;
      prRv_q   <= prRv_d;
      prGu_q   <= prGu_d;
      prGv_q   <= prGv_d;
      prBu_q   <= prBu_d;
      valid3_q <= valid2_q;
      sof3_q   <= sof2_q;
      eol3_q   <= eol2_q;
      rgb3_q   <= rgb3_d;
      clip3_q  <= clip3_d;
    end
  end

  // Count accepted clipped pixels; a clear wins over an increment and the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      satCnt_q <= '0;
    end else if (sat_clr) begin
      satCnt_q <= '0;
    end else if (valid3_q && m_ready && clip3_q && (satCnt_q != 16'hFFFF)) begin
      satCnt_q <= satCnt_q + 16'd1;
    end
  end

  assign m_valid = valid3_q;
  assign m_rgb   = rgb3_q;
  assign m_sof   = sof3_q;
  assign m_eol   = eol3_q;
  assign sat_cnt = satCnt_q;

endmodule

// File: tb/tb_ycbcr2rgb_stream.sv
// tb_ycbcr2rgb_stream: randomized and directed stimulus for ycbcr2rgb_stream.
// Expected pixels come from a plain-integer BT.601 model queued at input acceptance.
`timescale 1ns/1ps
module tb_ycbcr2rgb_stream;

`ifdef YCBCR2RGB_SKID_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, s_sof, s_eol;
  logic [35:0] s_ycbcr;
  logic        m_valid, m_ready, m_sof, m_eol;
  logic [23:0] m_rgb;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  int total = 0;
  int bad   = 0;
  int readyMode = 0;
  int patIdx = 0;

  typedef struct packed {
    logic [23:0] rgb;
    logic        clip;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  logic [15:0] satExp = 16'd0;
  logic        stallPrev = 1'b0;
  logic [25:0] heldOut = '0;
  logic        outClip;

  always #5 clk = ~clk;

  ycbcr2rgb_stream dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_ycbcr (s_ycbcr),
    .s_sof   (s_sof),
    .s_eol   (s_eol),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_rgb   (m_rgb),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .sat_clr (sat_clr),
    .sat_cnt (sat_cnt)
  );

  // One comparison: count it, and report it if it differs.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference conversion done directly with integers on the 2^-20 scale.
  function automatic exp_t refModel(input logic [35:0] pix, input logic sof, input logic eol);
    longint y, cb, cr;
    longint ch [3];
    exp_t   e;
    y  = longint'(pix[35:24]);
    cb = longint'(pix[23:12]) - 2048;
    cr = longint'(pix[11:0]) - 2048;
    ch[0] = (y*65536 + 91881*cr + 524288) >>> 20;
    ch[1] = (y*65536 - 22554*cb - 46802*cr + 524288) >>> 20;
    ch[2] = (y*65536 + 116130*cb + 524288) >>> 20;
    e.clip = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ch[i] < 0) begin
        ch[i] = 0;
        e.clip = 1'b1;
      end else if (ch[i] > 255) begin
        ch[i] = 255;
        e.clip = 1'b1;
      end
    end
    e.rgb = {ch[0][7:0], ch[1][7:0], ch[2][7:0]};
    e.sof = sof;
    e.eol = eol;
    return e;
  endfunction

  // Downstream ready generator: always, 1-0-0-1 pattern, random, or left to the main sequence.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = ((patIdx % 4) == 0) || ((patIdx % 4) == 3);
        patIdx++;
      end
      2: m_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  // Compare process: sampled mid-cycle when every DUT output and bench input is stable.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      satExp    = 16'd0;
      stallPrev = 1'b0;
    end else begin
      checkOutput("sat_cnt", sat_cnt, satExp);
`ifndef YCBCR2RGB_SKID_EN
      checkOutput("s_ready", s_ready, !m_valid || m_ready);
`endif
      if (stallPrev) begin
        checkOutput("stall_valid", m_valid, 1);
        checkOutput("stall_hold", {m_rgb, m_sof, m_eol}, heldOut);
      end
      outClip = 1'b0;
      if (m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got 0x%0h, expected no pixel", m_rgb);
        end else begin
          monE = expQ.pop_front();
          checkOutput("m_rgb", m_rgb, monE.rgb);
          checkOutput("m_sof", m_sof, monE.sof);
          checkOutput("m_eol", m_eol, monE.eol);
          outClip = monE.clip;
        end
      end
      if (s_valid && s_ready) begin
        expQ.push_back(refModel(s_ycbcr, s_sof, s_eol));
      end
      if (sat_clr) begin
        satExp = 16'd0;
      end else if (outClip && satExp != 16'hFFFF) begin
        satExp = satExp + 16'd1;
      end
      stallPrev = m_valid && !m_ready;
      heldOut   = {m_rgb, m_sof, m_eol};
    end
  end

  // Offer one pixel and hold it until it is accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [35:0] pix, input logic sof, input logic eol);
    int n = 0;
    s_valid = 1'b1;
    s_ycbcr = pix;
    s_sof   = sof;
    s_eol   = eol;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout: got s_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  // Count mid-cycle samples until m_valid rises; leaves the caller at that negedge.
  task automatic waitOutput(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (m_valid) break;
    end
    if (!m_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL output_timeout: got m_valid=0 after %0d cycles, expected a pixel", lat);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || m_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_done", (n < 500), 1);
  endtask

  task automatic stepToPosedge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int stale;
    logic [35:0] pix;
    rst = 1'b1; s_valid = 1'b0; s_ycbcr = '0; s_sof = 1'b0; s_eol = 1'b0;
    sat_clr = 1'b0; m_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_rgb",   m_rgb, 0);
    checkOutput("rst_m_sof",   m_sof, 0);
    checkOutput("rst_m_eol",   m_eol, 0);
    checkOutput("rst_sat_cnt", sat_cnt, 0);
    #2 rst = 1'b0;
    stepToPosedge();
    checkOutput("ready_after_rst", s_ready, 1);

    // Mid grey: exact latency and value
    applyStimulus(36'h800800800, 1'b0, 1'b0);
    waitOutput(lat);
    checkOutput("latency", lat, LAT);
    checkOutput("grey_rgb", m_rgb, 24'h808080);
    stepToPosedge();
    @(negedge clk);
    checkOutput("grey_sat_cnt", sat_cnt, 0);
    stepToPosedge();

    // Bright red-ish: R clipped
    applyStimulus(36'hFF0800FF0, 1'b0, 1'b0);
    waitOutput(lat);
    checkOutput("bright_rgb", m_rgb, 24'hFFA4FF);
    stepToPosedge();
    @(negedge clk);
    checkOutput("bright_sat_cnt", sat_cnt, 1);
    stepToPosedge();

    // All-zero input: R and B clipped low
    applyStimulus(36'h000000000, 1'b0, 1'b0);
    waitOutput(lat);
    checkOutput("zero_rgb", m_rgb, 24'h008700);
    stepToPosedge();
    @(negedge clk);
    checkOutput("zero_sat_cnt", sat_cnt, 2);
    stepToPosedge();

    // Clear coincident with an accepted clipped pixel
    readyMode = 3;
    m_ready = 1'b0;
    applyStimulus(36'h000000000, 1'b0, 1'b0);
    waitOutput(lat);
    stepToPosedge();
    m_ready = 1'b1;
    sat_clr = 1'b1;
    stepToPosedge();
    sat_clr = 1'b0;
    @(negedge clk);
    checkOutput("sat_clr_priority", sat_cnt, 0);
    stepToPosedge();

    // 16-pixel burst under a 1,0,0,1 ready pattern with sideband on pixels 0 and 7
    patIdx = 0;
    readyMode = 1;
    for (int i = 0; i < 16; i++) begin
      pix = {$urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095)};
      applyStimulus(pix, (i == 0), (i == 7));
    end
    drain();

    // Randomized traffic with random backpressure and gaps
    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        pix = {($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000,
               ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000,
               ($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000};
      end else begin
        pix = {$urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095)};
      end
      applyStimulus(pix, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      repeat ($urandom_range(0, 2)) stepToPosedge();
    end
    drain();

    // Reset with pixels in flight
    readyMode = 0;
    stepToPosedge();
    for (int i = 0; i < 3; i++) begin
      applyStimulus({$urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095)},
                    1'b0, 1'b0);
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_m_valid", m_valid, 0);
    checkOutput("async_rst_m_rgb", m_rgb, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid) stale++;
    end
    checkOutput("no_stale_pixel", stale, 0);
    stepToPosedge();
    applyStimulus(36'h800800800, 1'b1, 1'b1);
    waitOutput(lat);
    checkOutput("post_rst_latency", lat, LAT);
    checkOutput("post_rst_rgb", m_rgb, 24'h808080);
    checkOutput("post_rst_sof_eol", {m_sof, m_eol}, 2'b11);
    stepToPosedge();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion by 1 ms, expected summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ycbcr2rgb_stream.md
Name: ycbcr2rgb_stream

Overview:
Pipelined BT.601 full-range YCbCr-to-RGB converter with valid/ready streaming handshake. It is the decode direction of the upsampling path's RGB-to-YCbCr stage. It takes 12-bit fixed-point Y/Cb/Cr pixels after chroma upsampling and returns packed 8-bit RGB to the video output. It also passes frame/line sideband through the pipeline and counts clipped pixels for debug.

Parameters:
PIXEL_WIDTH, 24, packed RGB output width (3*RGB_WIDTH)
RGB_WIDTH, 8, bits per output colour channel
YCbCr_WIDTH, 12, bits per input component; unsigned, YCbCr_WIDTH-RGB_WIDTH (=4) fractional bits
YCbCr_PARA_WIDTH, 20, coefficient register width; coefficients are unsigned with 16 fractional bits

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
s_valid  in  1  input pixel valid
s_ready  out  1  block accepts input this cycle
s_ycbcr  in  3*YCbCr_WIDTH  {Y,Cb,Cr}, Y in MSBs
s_sof  in  1  first pixel of frame (sideband)
s_eol  in  1  last pixel of line (sideband)
m_valid  out  1  output pixel valid
m_ready  in  1  downstream accepts output
m_rgb  out  PIXEL_WIDTH  {R,G,B}, R in MSBs
m_sof  out  1  delayed s_sof
m_eol  out  1  delayed s_eol
sat_clr  in  1  synchronous clear of sat_cnt
sat_cnt  out  16  count of clipped pixels, saturating at 0xFFFF

Behaviour:
- Reset (async, rst=1): all pipeline valid bits 0, m_valid=0, m_rgb=0, m_sof=0, m_eol=0, sat_cnt=0. s_ready=1 once rst deasserts. Reset mid-frame discards in-flight pixels.
- Pipeline: 3 register stages; latency is 3 cycles from the accepting s_valid&s_ready edge to m_valid with no backpressure. Full throughput of 1 pixel/clk.
- Stall: advance = ~m_valid | m_ready. Every stage (data, valid, sideband) loads only when advance=1, so the whole pipe freezes together. s_ready = advance (combinational, default build).
- While m_valid=1 and m_ready=0, m_rgb, m_sof and m_eol hold stable. No pixel is dropped or duplicated.
- Stage 1: Cb_c = Cb - 2048 and Cr_c = Cr - 2048, as 13-bit signed values. Y is registered alongside them.
- Stage 2: signed products with coefficients K_RV=91881, K_GU=22554, K_GV=46802, K_BU=116130. Result is 31-bit signed; scale is 2^-20.
- Stage 3:
  - Y20 = Y<<16.
  - R = Y20 + K_RV*Cr_c.
  - G = Y20 - K_GU*Cb_c - K_GV*Cr_c.
  - B = Y20 + K_BU*Cb_c.
  - Each sum is 33-bit signed. Add 2^19, then arithmetic shift right by 20 (round half up).
  - Clamp to [0,255]. clip = any channel clamped.
- sat_cnt increments by 1 when a pixel with clip=1 is accepted at the output (m_valid&m_ready). It holds at 0xFFFF.
- sat_clr has priority over an increment in the same cycle.
- Sideband travels with its pixel and gets no special handling. A pixel with s_sof=s_eol=1 passes both flags through.

Optional Feature:
YCBCR2RGB_SKID_EN
- Defined: s_ready is a register, with no combinational path from m_ready. A 2-entry skid buffer at the input absorbs one in-flight pixel when s_ready drops. s_ready = buffer not full.
  - Latency becomes 4 cycles.
  - Throughput stays 1 pixel/clk when m_ready stays high.
  - Reset empties the skid buffer and sets s_ready=0 during reset, 1 after.
- Undefined: s_ready = advance as above; latency 3.

Test Plan:
- Y=0x800, Cb=0x800, Cr=0x800, single pixel, m_ready=1 -> m_rgb=0x808080 exactly 3 cycles later; sat_cnt stays 0.
- Y=0xFF0, Cb=0x800, Cr=0xFF0 -> m_rgb=0xFFA4FF (R clipped from 433, G=164); sat_cnt=1.
- Y=0x000, Cb=0x000, Cr=0x000 -> m_rgb=0x008700 (R,B clipped, G=135); sat_cnt increments.
- 16-pixel burst while m_ready toggles 1,0,0,1 repeatedly -> all 16 outputs in order, m_rgb stable while stalled, no loss or duplication, s_ready low exactly when m_valid&~m_ready.
- Sideband: s_sof on pixel 0 and s_eol on pixel 7 -> m_sof/m_eol asserted only on output pixels 0 and 7. sat_clr pulse while a clipped pixel is accepted -> sat_cnt=0.
- Assert rst with 3 pixels in flight -> m_valid=0 immediately (async); no stale pixel after release. With YCBCR2RGB_SKID_EN, latency is 4 and there is no comb path from m_ready to s_ready.
